// File: rtl/alien_hit_detector_pkg.sv
// Shared game constants and the alive-bitmap indexing helper.
package alien_hit_detector_pkg;

    // Screen coordinate widths
    localparam int unsigned X_W = 5;
    localparam int unsigned Y_W = 4;

    // Default formation geometry
    localparam int unsigned DEF_COLS      = 8;
    localparam int unsigned DEF_ROWS      = 4;
    localparam int unsigned DEF_COL_PITCH = 2;
    localparam int unsigned DEF_ROW_PITCH = 2;

    // Bit position of (row, col) in the alive bitmap
    function automatic int unsigned cell_index(int unsigned row, int unsigned col,
                                               int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/alien_hit_detector_if.sv
// Bullet position interface: the bullet drives its position, the detector answers with hit.
interface alien_hit_detector_if
    import alien_hit_detector_pkg::*;
();
    logic           flying;
    logic [X_W-1:0] bulletX;
    logic [Y_W-1:0] bulletY;
    logic           hit;

    modport master (output flying, output bulletX, output bulletY, input hit);
    modport slave  (input flying, input bulletX, input bulletY, output hit);
endinterface

// File: rtl/alien_cell_match.sv
// Maps a screen position onto a formation cell; shared with the display renderer.
module alien_cell_match
    import alien_hit_detector_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned COL_PITCH = DEF_COL_PITCH,
    parameter int unsigned ROW_PITCH = DEF_ROW_PITCH
) (
    input  logic [X_W-1:0] bulletX,
    input  logic [Y_W-1:0] bulletY,
    input  logic [X_W-1:0] alienX,
    input  logic [Y_W-1:0] alienY,
    output logic           candidate,
    output logic [X_W-1:0] col,
    output logic [Y_W-1:0] row
);
    localparam int unsigned    COL_SH   = $clog2(COL_PITCH);
    localparam int unsigned    ROW_SH   = $clog2(ROW_PITCH);
    localparam logic [X_W-1:0] COL_MASK = X_W'(COL_PITCH - 1);
    localparam logic [Y_W-1:0] ROW_MASK = Y_W'(ROW_PITCH - 1);

    logic [X_W:0] dx;
    logic [Y_W:0] dy;

    // Offset from origin; the extra top bit flags a bullet left of / above the formation
    always_comb begin
        dx = {1'b0, bulletX} - {1'b0, alienX};
        dy = {1'b0, bulletY} - {1'b0, alienY};
        col = dx[X_W-1:0] >> COL_SH;
        row = dy[Y_W-1:0] >> ROW_SH;
        candidate = !dx[X_W] && !dy[Y_W]
                    && ((dx[X_W-1:0] & COL_MASK) == '0)
                    && ((dy[Y_W-1:0] & ROW_MASK) == '0)
                    && (32'(col) < COLS)
                    && (32'(row) < ROWS);
    end

endmodule

// File: rtl/alien_hit_detector.sv
// Alien formation hit detection, live count, score and explosion marker.
module alien_hit_detector
    import alien_hit_detector_pkg::*;
#(
    parameter int unsigned COLS           = DEF_COLS,
    parameter int unsigned ROWS           = DEF_ROWS,
    parameter int unsigned COL_PITCH      = DEF_COL_PITCH,
    parameter int unsigned ROW_PITCH      = DEF_ROW_PITCH,
    parameter int unsigned EXPLODE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   enable,
    alien_hit_detector_if.slave    bullet,
    input  logic [X_W-1:0]         alienX,
    input  logic [Y_W-1:0]         alienY,
    output logic [ROWS*COLS-1:0]   alive,
    output logic [7:0]             alive_count,
    output logic                   all_dead,
    output logic [7:0]             score,
    output logic                   exploding,
    output logic [X_W-1:0]         explodeX,
    output logic [Y_W-1:0]         explodeY
);
    localparam int unsigned NCELL      = ROWS * COLS;
    localparam logic [7:0]  FULL_COUNT = 8'(NCELL);
    localparam logic [7:0]  EXP_LOAD   = 8'(EXPLODE_CYCLES);

    logic             candidate;
    logic [X_W-1:0]   col;
    logic [Y_W-1:0]   row;
    logic [NCELL-1:0] cell_sel;
    logic             hit_cond;

    logic             hit_q;
    logic [NCELL-1:0] alive_q;
    logic [7:0]       count_q;
    logic [7:0]       score_q;
    logic             exploding_q;
    logic [7:0]       exp_cnt_q;
    logic [X_W-1:0]   exp_x_q;
    logic [Y_W-1:0]   exp_y_q;

    alien_cell_match #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .COL_PITCH (COL_PITCH),
        .ROW_PITCH (ROW_PITCH)
    ) u_match (
        .bulletX   (bullet.bulletX),
        .bulletY   (bullet.bulletY),
        .alienX    (alienX),
        .alienY    (alienY),
        .candidate (candidate),
        .col       (col),
        .row       (row)
    );

    // One-hot select of the struck cell; !hit_q lets the bullet drop flying before re-arming
    always_comb begin
        cell_sel = '0;
        if (candidate) begin
            cell_sel = NCELL'(1) << cell_index(32'(row), 32'(col), COLS);
        end
        hit_cond = enable && bullet.flying && (|(cell_sel & alive_q)) && !hit_q && !clr;
    end

    // Hit pulse back to the bullet
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_cond;
        end
    end

    // Alive bitmap and live count; clr reloads the whole formation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q <= '1;
            count_q <= FULL_COUNT;
        end else if (clr) begin
            alive_q <= '1;
            count_q <= FULL_COUNT;
        end else if (hit_cond) begin
            alive_q <= alive_q & ~cell_sel;
            count_q <= count_q - 8'd1;
        end
    end

    // Saturating kill score, survives clr
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_q <= '0;
        end else if (hit_cond && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    // Explosion marker: loaded on a hit, counts down only while enabled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exploding_q <= 1'b0;
            exp_cnt_q   <= '0;
            exp_x_q     <= '0;
            exp_y_q     <= '0;
        end else if (clr) begin
            exploding_q <= 1'b0;
            exp_cnt_q   <= '0;
        end else if (hit_cond) begin
            exploding_q <= 1'b1;
            exp_cnt_q   <= EXP_LOAD;
            exp_x_q     <= bullet.bulletX;
            exp_y_q     <= bullet.bulletY;
        end else if (exploding_q && enable) begin
            // Dropping at the 1->0 step keeps the marker up for exactly EXPLODE_CYCLES cycles
            if (exp_cnt_q == 8'd1) begin
                exploding_q <= 1'b0;
                exp_cnt_q   <= '0;
            end else begin
                exp_cnt_q <= exp_cnt_q - 8'd1;
            end
        end
    end

    assign bullet.hit  = hit_q;
    assign alive       = alive_q;
    assign alive_count = count_q;
    assign all_dead    = (count_q == '0);
    assign score       = score_q;
    assign exploding   = exploding_q;
    assign explodeX    = exp_x_q;
    assign explodeY    = exp_y_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_alien_hit_detector;
    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int CP   = 2;
    localparam int RP   = 2;
    localparam int EXP  = 8;
    localparam int N    = ROWS * COLS;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        enable;
    logic [4:0]  alienX;
    logic [3:0]  alienY;
    logic [31:0] alive;
    logic [7:0]  alive_count;
    logic        all_dead;
    logic [7:0]  score;
    logic        exploding;
    logic [4:0]  explodeX;
    logic [3:0]  explodeY;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    alien_hit_detector_if bus ();

    alien_hit_detector #(
        .COLS           (COLS),
        .ROWS           (ROWS),
        .COL_PITCH      (CP),
        .ROW_PITCH      (RP),
        .EXPLODE_CYCLES (EXP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clr         (clr),
        .enable      (enable),
        .bullet      (bus.slave),
        .alienX      (alienX),
        .alienY      (alienY),
        .alive       (alive),
        .alive_count (alive_count),
        .all_dead    (all_dead),
        .score       (score),
        .exploding   (exploding),
        .explodeX    (explodeX),
        .explodeY    (explodeY)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: screen arithmetic on integers, explosion as cycles remaining
    bit          m_alive [N];
    int          m_count;
    int          m_score;
    int          m_exp_left;
    bit          m_hit;
    int          m_ex;
    int          m_ey;
    int          m_cell;
    bit          m_fire;
    logic [31:0] m_alive_vec;

    function automatic int cell_of(int bx, int by, int ax, int ay);
        int dx = bx - ax;
        int dy = by - ay;
        if (dx < 0 || dy < 0) return -1;
        if ((dx % CP) != 0 || (dy % RP) != 0) return -1;
        if (dx / CP >= COLS || dy / RP >= ROWS) return -1;
        return (dy / RP) * COLS + dx / CP;
    endfunction

    always_comb begin
        m_cell = cell_of(int'(bus.bulletX), int'(bus.bulletY), int'(alienX), int'(alienY));
        m_fire = 1'b0;
        if (m_cell >= 0) m_fire = enable && bus.flying && !clr && !m_hit && m_alive[m_cell];
        m_alive_vec = '0;
        for (int i = 0; i < N; i++) m_alive_vec[i] = m_alive[i];
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_alive    <= '{default: 1'b1};
            m_count    <= N;
            m_score    <= 0;
            m_exp_left <= 0;
            m_hit      <= 1'b0;
            m_ex       <= 0;
            m_ey       <= 0;
        end else if (clr) begin
            m_alive    <= '{default: 1'b1};
            m_count    <= N;
            m_exp_left <= 0;
            m_hit      <= 1'b0;
        end else begin
            m_hit <= m_fire;
            if (m_fire) begin
                m_alive[m_cell] <= 1'b0;
                m_count         <= m_count - 1;
                m_score         <= (m_score < 255) ? m_score + 1 : 255;
                m_exp_left      <= EXP;
                m_ex            <= int'(bus.bulletX);
                m_ey            <= int'(bus.bulletY);
            end else if (enable && m_exp_left > 0) begin
                m_exp_left <= m_exp_left - 1;
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("m_hit",       64'(bus.hit),     64'(m_hit));
            check("m_alive",     64'(alive),       64'(m_alive_vec));
            check("m_count",     64'(alive_count), 64'(m_count));
            check("m_all_dead",  64'(all_dead),    64'(m_count == 0));
            check("m_score",     64'(score),       64'(m_score));
            check("m_exploding", 64'(exploding),   64'(m_exp_left > 0));
            check("m_explodeX",  64'(explodeX),    64'(m_ex));
            check("m_explodeY",  64'(explodeY),    64'(m_ey));
        end
    end

    task automatic shoot(bit f, int bx, int by);
        bus.flying  = f;
        bus.bulletX = 5'(bx);
        bus.bulletY = 4'(by);
    endtask

    initial begin
        int ncount;
        reset  = 1'b0;
        clr    = 1'b0;
        enable = 1'b0;
        alienX = 5'd4;
        alienY = 4'd2;
        shoot(1'b0, 0, 0);
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_alive", 64'(alive), 64'hFFFF_FFFF);
        check("rst_count", 64'(alive_count), 64'd32);
        check("rst_score", 64'(score), 64'd0);
        check("rst_hit", 64'(bus.hit), 64'd0);
        check("rst_all_dead", 64'(all_dead), 64'd0);

        // Column 2, row 2 -> bit 18
        enable = 1'b1;
        shoot(1'b1, 8, 6);
        @(negedge clk);
        check("hit1", 64'(bus.hit), 64'd1);
        check("hit1_alive", 64'(alive), 64'hFFFB_FFFF);
        check("hit1_count", 64'(alive_count), 64'd31);
        check("hit1_score", 64'(score), 64'd1);
        check("hit1_ex", 64'(explodeX), 64'd8);
        check("hit1_ey", 64'(explodeY), 64'd6);
        check("hit1_exploding", 64'(exploding), 64'd1);
        ncount = 1;
        repeat (3) begin
            @(negedge clk);
            check("held_no_hit", 64'(bus.hit), 64'd0);
            ncount += int'(exploding);
        end
        check("held_count", 64'(alive_count), 64'd31);
        check("held_score", 64'(score), 64'd1);
        shoot(1'b0, 8, 6);
        repeat (8) begin
            @(negedge clk);
            ncount += int'(exploding);
        end
        check("explode_len", 64'(ncount), 64'd8);

        // Misses: odd dx, left of origin, row beyond formation
        shoot(1'b1, 9, 6);
        @(negedge clk);
        check("miss_odd", 64'(bus.hit), 64'd0);
        shoot(1'b1, 3, 6);
        @(negedge clk);
        check("miss_left", 64'(bus.hit), 64'd0);
        shoot(1'b1, 8, 14);
        @(negedge clk);
        check("miss_row", 64'(bus.hit), 64'd0);
        check("miss_count", 64'(alive_count), 64'd31);

        // Enable dropped for 5 cycles mid-explosion stretches it to 13 cycles
        shoot(1'b1, 4, 2);
        @(negedge clk);
        check("hit_cell0", 64'(bus.hit), 64'd1);
        shoot(1'b0, 4, 2);
        ncount = 1;
        repeat (2) begin
            @(negedge clk);
            ncount += int'(exploding);
        end
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            ncount += int'(exploding);
            check("explode_frozen", 64'(exploding), 64'd1);
        end
        enable = 1'b1;
        repeat (12) begin
            @(negedge clk);
            ncount += int'(exploding);
        end
        check("explode_paused_len", 64'(ncount), 64'd13);

        // Second hit three cycles into an explosion reloads it
        shoot(1'b1, 6, 2);
        @(negedge clk);
        check("hit_cell1", 64'(bus.hit), 64'd1);
        shoot(1'b0, 6, 2);
        repeat (2) @(negedge clk);
        shoot(1'b1, 10, 4);
        @(negedge clk);
        check("reload_hit", 64'(bus.hit), 64'd1);
        check("reload_ex", 64'(explodeX), 64'd10);
        check("reload_ey", 64'(explodeY), 64'd4);
        shoot(1'b0, 10, 4);
        ncount = 1;
        repeat (10) begin
            @(negedge clk);
            ncount += int'(exploding);
        end
        check("reload_len", 64'(ncount), 64'd8);

        // Asynchronous reset while hit and explosion are active
        shoot(1'b1, 12, 2);
        @(negedge clk);
        check("pre_reset_hit", 64'(bus.hit), 64'd1);
        shoot(1'b0, 12, 2);
        #1 reset = 1'b0;
        #1;
        check("async_hit", 64'(bus.hit), 64'd0);
        check("async_exploding", 64'(exploding), 64'd0);
        check("async_alive", 64'(alive), 64'hFFFF_FFFF);
        check("async_count", 64'(alive_count), 64'd32);
        check("async_score", 64'(score), 64'd0);
        check("async_ex", 64'(explodeX), 64'd0);
        check("async_ey", 64'(explodeY), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Wipe out the whole formation
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                shoot(1'b1, 4 + CP * c, 2 + RP * r);
                @(negedge clk);
                check("kill_hit", 64'(bus.hit), 64'd1);
                if (r == ROWS - 1 && c == COLS - 1) begin
                    check("last_all_dead", 64'(all_dead), 64'd1);
                end
                shoot(1'b0, 0, 0);
                @(negedge clk);
            end
        end
        check("dead_count", 64'(alive_count), 64'd0);
        check("dead_score", 64'(score), 64'd32);
        shoot(1'b1, 4, 2);
        @(negedge clk);
        check("dead_no_hit", 64'(bus.hit), 64'd0);
        check("dead_stays", 64'(all_dead), 64'd1);
        shoot(1'b0, 0, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr_alive", 64'(alive), 64'hFFFF_FFFF);
        check("clr_count", 64'(alive_count), 64'd32);
        check("clr_score", 64'(score), 64'd32);
        check("clr_all_dead", 64'(all_dead), 64'd0);

        // Randomized traffic biased toward the grid
        repeat (3000) begin
            alienX = 5'($urandom_range(0, 12));
            alienY = 4'($urandom_range(0, 6));
            shoot($urandom_range(0, 9) < 7,
                  int'(alienX) + int'($urandom_range(0, 18)) - 1,
                  int'(alienY) + int'($urandom_range(0, 9)) - 1);
            enable = $urandom_range(0, 9) < 8;
            clr    = $urandom_range(0, 99) == 0;
            @(negedge clk);
        end
        clr = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
